// File: rtl/rd_ws_responder_if.sv
// Bus bundle for the rd/ws/ds read handshake plus the storage side-write port.
// master: initiator side (drives rd/addr/wait_cfg and the write port).
// slave : responder side (drives ws/rdata/rvalid/busy/proto_err).
interface rd_ws_responder_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 3
);
  logic              rd;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  wait_cfg;
  logic              ws;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic              busy;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              proto_err;

  modport master (
    output rd, addr, wait_cfg, we, waddr, wdata,
    input  ws, rdata, rvalid, busy, proto_err
  );

  modport slave (
    input  rd, addr, wait_cfg, we, waddr, wdata,
    output ws, rdata, rvalid, busy, proto_err
  );
endinterface

// File: rtl/rd_ws_responder.sv
// Target-side responder for the rd/ws/ds read handshake.
// Inserts wait_cfg ws pulses (one per initiator DELAY cycle), then returns
// one word from a local register-file memory with rvalid aligned to ds.
// Optional feature macro: RESP_PROTO_CHK_EN -- when defined, proto_err is a
// sticky flag set by any handshake violation; otherwise proto_err is tied 0.
// The FSM aborts to IDLE on violations in both builds.
module rd_ws_responder #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 3
) (
  input  logic                clock,
  input  logic                reset_n,
  rd_ws_responder_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_B    = 2'd1,
    RD_A    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] rdata_q;
  logic              rvalid_q;

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Side write port; independent of the FSM and never reset.
  always_ff @(posedge clock) begin
    if (bus.we) begin
      mem[bus.waddr] <= bus.wdata;
    end
  end

  // Handshake FSM: address/count capture, wait-state countdown, read and release.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      addr_q   <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.rd) begin
            addr_q <= bus.addr;
            cnt    <= bus.wait_cfg;
            state  <= RD_B;
          end
        end
        RD_B: begin
          if (!bus.rd) begin
            state <= IDLE;
          end else if (cnt != '0) begin
            cnt   <= cnt - CNT_W'(1);
            state <= RD_A;
          end else begin
            // Non-blocking read: a same-edge write to addr_q is not seen.
            rdata_q  <= mem[addr_q];
            rvalid_q <= 1'b1;
            state    <= RELEASE;
          end
        end
        RD_A: begin
          state <= bus.rd ? RD_B : IDLE;
        end
        RELEASE: begin
          // rd still high here is a violation, never the start of a new access.
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.ws     = (state == RD_B) && (cnt != '0);
  assign bus.busy   = (state != IDLE);
  assign bus.rdata  = rdata_q;
  assign bus.rvalid = rvalid_q;

`ifdef RESP_PROTO_CHK_EN
  logic err_set;
  logic proto_err_q;

  // Violation detect: rd dropped mid-access, or rd still high in RELEASE.
  always_comb begin
    err_set = 1'b0;
    case (state)
      RD_B, RD_A: err_set = !bus.rd;
      RELEASE:    err_set = bus.rd;
      default:    err_set = 1'b0;
    endcase
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      proto_err_q <= 1'b0;
    end else if (err_set) begin
      proto_err_q <= 1'b1;
    end
  end

  assign bus.proto_err = proto_err_q;
`else
  assign bus.proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_rd_ws_responder.sv
// Directed bench for rd_ws_responder: a cycle-by-cycle vector table for the
// normal read paths and write collisions, plus hand sequences for reset
// during an access, maximum wait count, rd held into RELEASE and early rd drop.
module tb_rd_ws_responder;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int CNT_W  = 3;

`ifdef RESP_PROTO_CHK_EN
  localparam logic PE_EXP = 1'b1;
`else
  localparam logic PE_EXP = 1'b0;
`endif

  logic clock;
  logic reset_n;

  rd_ws_responder_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  rd_ws_responder #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic              rd;
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  wcfg;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              e_ws;
    logic              e_rv;
    logic [DATA_W-1:0] e_rdata;
    logic              e_busy;
  } vec_t;

  vec_t vecs[$];

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void add(input logic rd, input int addr, input int wcfg,
                              input logic we, input int waddr, input int wdata,
                              input logic e_ws, input logic e_rv,
                              input int e_rdata, input logic e_busy);
    vec_t v;
    v.rd = rd; v.addr = addr[ADDR_W-1:0]; v.wcfg = wcfg[CNT_W-1:0];
    v.we = we; v.waddr = waddr[ADDR_W-1:0]; v.wdata = wdata[DATA_W-1:0];
    v.e_ws = e_ws; v.e_rv = e_rv; v.e_rdata = e_rdata[DATA_W-1:0];
    v.e_busy = e_busy;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply inputs just after the rising edge, then wait for the falling edge to sample.
  task automatic drive(input logic rd, input int addr, input int wcfg,
                       input logic we, input int waddr, input int wdata);
    @(posedge clock);
    #1;
    bus.rd       = rd;
    bus.addr     = addr[ADDR_W-1:0];
    bus.wait_cfg = wcfg[CNT_W-1:0];
    bus.we       = we;
    bus.waddr    = waddr[ADDR_W-1:0];
    bus.wdata    = wdata[DATA_W-1:0];
    @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    bus.rd = 1'b0;
    bus.we = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    int rv_at;
    int ws_cnt;
    logic [DATA_W-1:0] rd_seen;

    reset_n      = 1'b0;
    bus.rd       = 1'b0;
    bus.addr     = '0;
    bus.wait_cfg = '0;
    bus.we       = 1'b0;
    bus.waddr    = '0;
    bus.wdata    = '0;
    repeat (3) @(negedge clock);

    // Reset state
    chk("rst_ws",     bus.ws,        0);
    chk("rst_rvalid", bus.rvalid,    0);
    chk("rst_rdata",  bus.rdata,     0);
    chk("rst_busy",   bus.busy,      0);
    chk("rst_perr",   bus.proto_err, 0);
    reset_n = 1'b1;

    //   rd addr wc we wa wd      ws rv rdata busy
    add(0, 0, 0, 1, 3, 8'hA5,    0, 0, 8'h00, 0);
    add(0, 0, 0, 1, 7, 8'h3C,    0, 0, 8'h00, 0);
    add(0, 0, 0, 1, 5, 8'h22,    0, 0, 8'h00, 0);
    // zero-wait read of mem[3]; addr/wait_cfg change after t is ignored
    add(1, 3, 0, 0, 0, 0,        0, 0, 8'h00, 0);
    add(1, 7, 5, 0, 0, 0,        0, 0, 8'h00, 1);
    add(0, 0, 0, 0, 0, 0,        0, 1, 8'hA5, 1);
    add(0, 0, 0, 0, 0, 0,        0, 0, 8'hA5, 0);
    // two-wait read of mem[7]
    add(1, 7, 2, 0, 0, 0,        0, 0, 8'hA5, 0);
    add(1, 0, 0, 0, 0, 0,        1, 0, 8'hA5, 1);
    add(1, 0, 0, 0, 0, 0,        0, 0, 8'hA5, 1);
    add(1, 0, 0, 0, 0, 0,        1, 0, 8'hA5, 1);
    add(1, 0, 0, 0, 0, 0,        0, 0, 8'hA5, 1);
    add(1, 0, 0, 0, 0, 0,        0, 0, 8'hA5, 1);
    add(0, 0, 0, 0, 0, 0,        0, 1, 8'h3C, 1);
    add(0, 0, 0, 0, 0, 0,        0, 0, 8'h3C, 0);
    // one-wait read of mem[5] with a write at t+2: new data returned
    add(1, 5, 1, 0, 0, 0,        0, 0, 8'h3C, 0);
    add(1, 0, 0, 0, 0, 0,        1, 0, 8'h3C, 1);
    add(1, 0, 0, 1, 5, 8'h11,    0, 0, 8'h3C, 1);
    add(1, 0, 0, 0, 0, 0,        0, 0, 8'h3C, 1);
    add(0, 0, 0, 0, 0, 0,        0, 1, 8'h11, 1);
    add(0, 0, 0, 0, 0, 0,        0, 0, 8'h11, 0);
    // same access with the write in the final RD_B: old data returned
    add(1, 5, 1, 0, 0, 0,        0, 0, 8'h11, 0);
    add(1, 0, 0, 0, 0, 0,        1, 0, 8'h11, 1);
    add(1, 0, 0, 0, 0, 0,        0, 0, 8'h11, 1);
    add(1, 0, 0, 1, 5, 8'h66,    0, 0, 8'h11, 1);
    add(0, 0, 0, 0, 0, 0,        0, 1, 8'h11, 1);
    add(0, 0, 0, 0, 0, 0,        0, 0, 8'h11, 0);
    // the late write did land
    add(1, 5, 0, 0, 0, 0,        0, 0, 8'h11, 0);
    add(1, 0, 0, 0, 0, 0,        0, 0, 8'h11, 1);
    add(0, 0, 0, 0, 0, 0,        0, 1, 8'h66, 1);
    add(0, 0, 0, 0, 0, 0,        0, 0, 8'h66, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].rd, int'(vecs[i].addr), int'(vecs[i].wcfg),
            vecs[i].we, int'(vecs[i].waddr), int'(vecs[i].wdata));
      chk($sformatf("v%0d_ws", i),     bus.ws,        vecs[i].e_ws);
      chk($sformatf("v%0d_rvalid", i), bus.rvalid,    vecs[i].e_rv);
      chk($sformatf("v%0d_rdata", i),  bus.rdata,     vecs[i].e_rdata);
      chk($sformatf("v%0d_busy", i),   bus.busy,      vecs[i].e_busy);
      chk($sformatf("v%0d_perr", i),   bus.proto_err, 0);
    end

    // Reset asserted while in RD_A: outputs clear immediately
    drive(1, 3, 2, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    chk("rsta_busy_before", bus.busy, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("rsta_ws",     bus.ws,     0);
    chk("rsta_rvalid", bus.rvalid, 0);
    chk("rsta_busy",   bus.busy,   0);
    chk("rsta_rdata",  bus.rdata,  0);
    bus.rd = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    drive(1, 3, 0, 0, 0, 0);
    chk("rsta_t_busy", bus.busy, 0);
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    chk("rsta_rvalid2", bus.rvalid, 1);
    chk("rsta_rdata2",  bus.rdata,  8'hA5);
    drive(0, 0, 0, 0, 0, 0);
    chk("rsta_idle", bus.busy, 0);

    // Maximum wait count: 7 ws pulses, rvalid at t+16
    rv_at = -1;
    ws_cnt = 0;
    rd_seen = '0;
    drive(1, 7, 7, 0, 0, 0);
    for (int k = 1; k <= 20; k++) begin
      drive(k <= 15, 0, 0, 0, 0, 0);
      if (bus.ws === 1'b1) ws_cnt++;
      if (bus.rvalid === 1'b1 && rv_at < 0) begin
        rv_at = k;
        rd_seen = bus.rdata;
      end
    end
    chk("max_ws_count", ws_cnt,  7);
    chk("max_rv_cycle", rv_at,   16);
    chk("max_rdata",    rd_seen, 8'h3C);
    chk("max_perr",     bus.proto_err, 0);

    // rd held into RELEASE: flagged, and not taken as a new access
    drive(1, 3, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    chk("rel_rvalid", bus.rvalid, 1);
    drive(0, 0, 0, 0, 0, 0);
    chk("rel_busy",   bus.busy,      0);
    chk("rel_rvalid_off", bus.rvalid, 0);
    chk("rel_perr",   bus.proto_err, PE_EXP);

    // Early rd drop in RD_A with wait_cfg=3
    do_reset();
    drive(1, 7, 3, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    chk("drop_ws_t1", bus.ws, 1);
    drive(0, 0, 0, 0, 0, 0);
    chk("drop_perr_t2", bus.proto_err, 0);
    for (int k = 3; k <= 6; k++) begin
      drive(0, 0, 0, 0, 0, 0);
      chk($sformatf("drop_rvalid_t%0d", k), bus.rvalid,    0);
      chk($sformatf("drop_busy_t%0d", k),   bus.busy,      0);
      chk($sformatf("drop_ws_t%0d", k),     bus.ws,        0);
      chk($sformatf("drop_perr_t%0d", k),   bus.proto_err, PE_EXP);
    end
    chk("drop_rdata_hold", bus.rdata, 0);
    // following clean access completes, flag stays
    drive(1, 3, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    chk("post_rvalid", bus.rvalid,    1);
    chk("post_rdata",  bus.rdata,     8'hA5);
    drive(0, 0, 0, 0, 0, 0);
    chk("post_busy",   bus.busy,      0);
    chk("post_perr",   bus.proto_err, PE_EXP);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
